spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter SYS_CLK, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter SPI_FREQ, default 5_000_000: SCK frequency in Hz; HALF = SYS_CLK/(2*SPI_FREQ) clk cycles per SCK half-period, HALF >= 1 required.
REQ-003 Parameter SPI_MODE, default 0, range 0..3: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
REQ-004 Parameter SPI_WIDTH, default 8: bits per transfer.
REQ-005 Parameter SPI_MSB, default 1: 1 = MSB first, 0 = LSB first, for both MOSI and MISO.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-high (asserted when 1).
REQ-008 spi_wr_cmd  in  1  write request: drive mosi_data on MOSI.
REQ-009 spi_rd_cmd  in  1  read request: capture MISO into miso_data.
REQ-010 mosi_data  in  SPI_WIDTH  word to transmit.
REQ-011 miso_data  out  SPI_WIDTH  last received word.
REQ-012 SCK  out  1  serial clock.
REQ-013 MOSI  out  1  serial data out.
REQ-014 CS  out  1  chip select, active-low.
REQ-015 MISO  in  1  serial data in.

Function
REQ-016 States: IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-017 cmd = spi_wr_cmd | spi_rd_cmd; start = rising edge of cmd (registered previous value), so a command held high for many cycles starts exactly one transfer.
REQ-018 In IDLE, start -> SETUP: CS=0; latch mosi_data, wr flag, rd flag; load first bit (bit SPI_WIDTH-1 if SPI_MSB else bit 0) onto MOSI if wr flag, else MOSI=0.
REQ-019 Starts arriving outside IDLE are ignored; mosi_data changes after latching are ignored.
REQ-020 SETUP lasts HALF cycles, then SHIFT; SHIFT toggles SCK every HALF cycles for exactly 2*SPI_WIDTH edges, beginning from CPOL.
REQ-021 CPHA=0: sample MISO on each leading (odd) edge; advance MOSI to next bit on each trailing edge except the last.
REQ-022 CPHA=1: advance MOSI on each leading edge (first leading edge presents the first bit; MOSI in SETUP is don't-care-driven 0); sample MISO on each trailing edge.
REQ-023 Received bits are assembled in the same bit order as transmit (SPI_MSB).
REQ-024 After the last edge SCK rests at CPOL; HOLD lasts HALF cycles with CS=0, then CS=1, MOSI=0.
REQ-025 On CS rising, miso_data updates to the received word only if rd flag set; otherwise it keeps its previous value.
REQ-026 GAP lasts HALF cycles with CS=1, then IDLE; minimum CS-high time between transfers is HALF cycles.
REQ-027 With wr flag clear, MOSI stays 0 throughout the transfer; the full SCK/CS sequence still runs.
REQ-028 Total transfer: CS low for (2*SPI_WIDTH+2)*HALF cycles.

Reset
REQ-029 While rst_n=1: state IDLE, SCK=CPOL, CS=1, MOSI=0, miso_data=0, internal counters/shift registers/flags cleared, edge detector previous value=0.
REQ-030 Reset mid-transfer aborts immediately to reset values; no partial miso_data update; after release a new rising edge of cmd is required.

Verification
REQ-031 Mode 0, LSB first, defaults, wr+rd asserted 10 cycles with mosi_data=0xC9, MISO=1 -> one transfer; MOSI on leading edges 1,0,0,1,0,0,1,1; 8 SCK pulses idle-low; miso_data=0xFF after CS rises; CS low 90 cycles.
REQ-032 Same stimulus in modes 1, 2, 3 -> SCK idles 0,1,1 respectively; sampling on trailing (mode 1, 3) or leading (mode 2) edge; identical MOSI bit sequence and miso_data=0xFF.
REQ-033 SPI_MSB=1, mosi_data=0xA5, MISO driven by a mode-matched slave model returning 0x3C -> MOSI 1,0,1,0,0,1,0,1; miso_data=0x3C.
REQ-034 wr_cmd only with miso_data previously 0x3C -> full SCK/CS sequence, miso_data remains 0x3C; rd_cmd only -> MOSI constantly 0, miso_data updated.
REQ-035 Assert rst_n mid-transfer (after 3 bits) -> CS=1, SCK=CPOL, MOSI=0, miso_data=0 asynchronously; held cmd after release starts nothing until a new rising edge.
REQ-036 Second cmd edge during a transfer -> ignored; one CS-low window only.

Source files
------------

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Single-word SPI master. A rising edge on (spi_wr_cmd |
//            spi_rd_cmd) starts one transfer of SPI_WIDTH bits in the
//            configured SPI mode and bit order. Chip select is framed by a
//            half-period setup before the first SCK edge, a half-period hold
//            after the last one, and a half-period minimum CS-high gap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active HIGH despite the name
//   spi_wr_cmd in   request: transmit mosi_data on MOSI
//   spi_rd_cmd in   request: capture MISO into miso_data
//   mosi_data  in   [SPI_WIDTH-1:0] word to transmit (latched at start)
//   miso_data  out  [SPI_WIDTH-1:0] last word received with rd requested
//   SCK        out  serial clock, idles at CPOL
//   MOSI       out  serial data out, 0 whenever not transmitting
//   CS         out  chip select, active low
//   MISO       in   serial data in
// ============================================================================
module spi_master #(
  parameter int SYS_CLK   = 50_000_000,
  parameter int SPI_FREQ  = 5_000_000,
  parameter int SPI_MODE  = 0,
  parameter int SPI_WIDTH = 8,
  parameter int SPI_MSB   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_wr_cmd,
  input  logic                 spi_rd_cmd,
  input  logic [SPI_WIDTH-1:0] mosi_data,
  output logic [SPI_WIDTH-1:0] miso_data,
  output logic                 SCK,
  output logic                 MOSI,
  output logic                 CS,
  input  logic                 MISO
);

  // Clock cycles per SCK half-period; the parameters must give c_HALF >= 1.
  localparam int c_HALF   = SYS_CLK / (2 * SPI_FREQ);
  localparam int c_CNT_W  = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam int c_EDGE_W = $clog2(2 * SPI_WIDTH + 1);

  localparam logic c_CPOL = ((SPI_MODE / 2) % 2) != 0;
  localparam logic c_CPHA = (SPI_MODE % 2) != 0;
  localparam logic c_MSB  = SPI_MSB != 0;

  localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(c_HALF - 1);
  localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * SPI_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;       // cycles elapsed in current half-period
  logic [c_EDGE_W-1:0]   r_edge_cnt;  // SCK edges already produced
  logic [SPI_WIDTH-1:0]  r_tx_sr;     // bits still to be shifted out
  logic [SPI_WIDTH-1:0]  r_rx_sr;     // bits received so far
  logic                  r_wr;
  logic                  r_rd;
  logic                  r_cmd_prev;
  // Set once cmd has been seen low since reset. The edge detector's previous
  // value resets to 0, so without this a command held high across reset
  // release would look like a fresh rising edge.
  logic                  r_armed;

  logic                  w_cmd;
  logic                  w_start;
  logic                  w_half_done;
  logic                  w_leading;
  logic                  w_sample;
  logic                  w_last_edge;
  logic                  w_tx_bit;
  logic [SPI_WIDTH-1:0]  w_tx_shifted;
  logic                  w_first_bit;
  logic [SPI_WIDTH-1:0]  w_data_shifted;
  logic [SPI_WIDTH:0]    w_rx_ext_msb;
  logic [SPI_WIDTH:0]    w_rx_ext_lsb;
  logic [SPI_WIDTH-1:0]  w_rx_next;

  assign w_cmd       = spi_wr_cmd | spi_rd_cmd;
  assign w_start     = w_cmd & ~r_cmd_prev & r_armed;
  assign w_half_done = (r_cnt == c_HALF_LAST);

  // The edge about to be produced is number r_edge_cnt+1; odd numbers are
  // leading edges (SCK leaving CPOL).
  assign w_leading   = ~r_edge_cnt[0];
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  assign w_sample    = w_leading ^ c_CPHA;
  assign w_last_edge = (r_edge_cnt == c_EDGE_LAST);

  // Transmit side: next bit and remaining word, in the configured order.
  assign w_tx_bit       = c_MSB ? r_tx_sr[SPI_WIDTH-1] : r_tx_sr[0];
  assign w_tx_shifted   = c_MSB ? (r_tx_sr << 1) : (r_tx_sr >> 1);
  assign w_first_bit    = c_MSB ? mosi_data[SPI_WIDTH-1] : mosi_data[0];
  assign w_data_shifted = c_MSB ? (mosi_data << 1) : (mosi_data >> 1);

  // Receive side: widen by one bit so the shift also works for SPI_WIDTH=1.
  assign w_rx_ext_msb = {r_rx_sr, MISO};
  assign w_rx_ext_lsb = {MISO, r_rx_sr};
  assign w_rx_next    = c_MSB ? w_rx_ext_msb[SPI_WIDTH-1:0]
                              : w_rx_ext_lsb[SPI_WIDTH:1];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_cmd_prev <= 1'b0;
      r_armed    <= 1'b0;
      SCK        <= c_CPOL;
      MOSI       <= 1'b0;
      CS         <= 1'b1;
      miso_data  <= '0;
    end else begin
      r_cmd_prev <= w_cmd;
      if (!w_cmd) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt      <= '0;
          r_edge_cnt <= '0;
          if (w_start) begin
            r_state <= ST_SETUP;
            CS      <= 1'b0;
            r_wr    <= spi_wr_cmd;
            r_rd    <= spi_rd_cmd;
            r_rx_sr <= '0;
            if (c_CPHA) begin
              // First bit is presented by the first leading edge.
              r_tx_sr <= mosi_data;
              MOSI    <= 1'b0;
            end else begin
              // First bit must be valid before the first leading edge.
              r_tx_sr <= w_data_shifted;
              MOSI    <= spi_wr_cmd & w_first_bit;
            end
          end
        end

        ST_SETUP: begin
          if (w_half_done) begin
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (w_half_done) begin
            r_cnt      <= '0;
            SCK        <= ~SCK;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            if (w_sample) begin
              r_rx_sr <= w_rx_next;
            end else if (!w_last_edge) begin
              // The final trailing edge (CPHA=0) has no further bit to show.
              MOSI    <= r_wr & w_tx_bit;
              r_tx_sr <= w_tx_shifted;
            end
            if (w_last_edge) begin
              r_state <= ST_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (w_half_done) begin
            r_cnt   <= '0;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
            if (r_rd) begin
              miso_data <= r_rx_sr;
            end
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (w_half_done) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          SCK     <= c_CPOL;
          MOSI    <= 1'b0;
          CS      <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master. Five instances share one
//            command stream: modes 0..3 LSB first, plus mode 0 MSB first.
//            Each instance has its own mode-matched slave model; the
//            expected result of each transfer is queued when the command is
//            driven and checked when that instance raises CS.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  localparam int NDUT = 5;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] data;
    logic [7:0] slave;
    logic [7:0] exp_mosi;
    logic [7:0] exp_miso;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_cmd = 1'b0;
  logic            rd_cmd = 1'b0;
  logic [7:0]      mosi_data = 8'h00;
  logic [7:0]      slave_word = 8'h00;
  logic [NDUT-1:0] sck_a;
  logic [NDUT-1:0] mosi_a;
  logic [NDUT-1:0] cs_a;
  logic [7:0]      md_a [NDUT];

  vec_t sb_q [NDUT][$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int dut,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h, want %0h", name, dut, act, exp);
    end
  endtask

  function automatic logic cpol_of(input int i);
    return (i < 4) ? (((i / 2) % 2) != 0) : 1'b0;
  endfunction

  // --------------------------------------------------------------------------
  // DUT instances with slave model and per-transfer monitor
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int   MODE = (g < 4) ? g : 0;
    localparam int   MSB  = (g == 4) ? 1 : 0;
    localparam logic CPOL = ((MODE / 2) % 2) != 0;
    localparam logic CPHA = (MODE % 2) != 0;

    logic       miso;
    logic       cs_prev;
    logic       sck_prev;
    logic       mosi_or;
    logic [7:0] stx;
    logic [7:0] srx;
    int         edges;
    int         lowcyc;
    vec_t       e;

    spi_master #(
      .SYS_CLK  (50_000_000),
      .SPI_FREQ (5_000_000),
      .SPI_MODE (MODE),
      .SPI_WIDTH(8),
      .SPI_MSB  (MSB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst),
      .spi_wr_cmd(wr_cmd),
      .spi_rd_cmd(rd_cmd),
      .mosi_data (mosi_data),
      .miso_data (md_a[g]),
      .SCK       (sck_a[g]),
      .MOSI      (mosi_a[g]),
      .CS        (cs_a[g]),
      .MISO      (miso)
    );

    // Slave model and monitor, evaluated on the falling clock edge.
    initial begin
      miso = 1'b0; cs_prev = 1'b1; sck_prev = CPOL; mosi_or = 1'b0;
      stx = 8'h00; srx = 8'h00; edges = 0; lowcyc = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          cs_prev = 1'b1; sck_prev = CPOL; miso = 1'b0;
        end else begin
          if (cs_prev && !cs_a[g]) begin
            stx = slave_word; srx = 8'h00; edges = 0; lowcyc = 0; mosi_or = 1'b0;
            if (!CPHA) begin
              if (MSB != 0) begin miso = stx[7]; stx = stx << 1; end
              else begin miso = stx[0]; stx = stx >> 1; end
            end
          end
          if (!cs_a[g] && (sck_a[g] != sck_prev)) begin
            edges++;
            if ((sck_prev == CPOL) != CPHA) begin
              if (MSB != 0) srx = {srx[6:0], mosi_a[g]};
              else srx = {mosi_a[g], srx[7:1]};
            end else begin
              if (MSB != 0) begin miso = stx[7]; stx = stx << 1; end
              else begin miso = stx[0]; stx = stx >> 1; end
            end
          end
          if (!cs_a[g]) begin
            lowcyc++;
            mosi_or = mosi_or | mosi_a[g];
          end
          if (!cs_prev && cs_a[g]) begin
            if (sb_q[g].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_xfer dut%0d: got a CS-low window, want none", g);
            end else begin
              e = sb_q[g].pop_front();
              check("mosi_word", g, 32'(srx), 32'(e.exp_mosi));
              check("miso_data", g, 32'(md_a[g]), 32'(e.exp_miso));
              check("sck_edges", g, 32'(edges), 32'd16);
              check("cs_low_cycles", g, 32'(lowcyc), 32'd90);
              check("mosi_any", g, 32'(mosi_or), 32'(e.exp_mosi != 8'h00));
              check("idle_lines", g, 32'({sck_a[g], mosi_a[g]}), 32'({CPOL, 1'b0}));
            end
          end
        end
        cs_prev  = cs_a[g];
        sck_prev = sck_a[g];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic check_drained();
    for (int i = 0; i < NDUT; i++) begin
      check("xfer_done", i, 32'(sb_q[i].size()), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    for (int i = 0; i < NDUT; i++) sb_q[i].push_back(v);
    @(posedge clk); #1;
    mosi_data  = v.data;
    slave_word = v.slave;
    wr_cmd     = v.wr;
    rd_cmd     = v.rd;
    repeat (hold) @(posedge clk);
    #1;
    wr_cmd    = 1'b0;
    rd_cmd    = 1'b0;
    mosi_data = 8'($urandom);     // must not leak into the running transfer
    repeat (120) @(posedge clk);
    check_drained();
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t tbl [6];
  vec_t v;
  int   lowseen;

  initial begin
      //          wr    rd    data   slave  exp_mosi exp_miso
    tbl[0] = {1'b1, 1'b1, 8'hC9, 8'hFF, 8'hC9, 8'hFF};
    tbl[1] = {1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    tbl[2] = {1'b1, 1'b0, 8'h5A, 8'h81, 8'h5A, 8'h3C};  // write only: keeps 0x3C
    tbl[3] = {1'b0, 1'b1, 8'hFF, 8'h96, 8'h00, 8'h96};  // read only: MOSI stays 0
    tbl[4] = {1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5] = {1'b1, 1'b1, 8'hFF, 8'h5A, 8'hFF, 8'h5A};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("reset_state", i, 32'({cs_a[i], sck_a[i], mosi_a[i], md_a[i]}),
            32'({1'b1, cpol_of(i), 1'b0, 8'h00}));
    end
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Table-driven transfers, command held for 10 cycles each
    for (int k = 0; k < 6; k++) begin
      run_vec(tbl[k], 10);
    end

    // A second command edge during a transfer must be ignored
    v = {1'b1, 1'b1, 8'h3A, 8'hC5, 8'h3A, 8'hC5};
    for (int i = 0; i < NDUT; i++) sb_q[i].push_back(v);
    @(posedge clk); #1;
    mosi_data = v.data; slave_word = v.slave; wr_cmd = 1'b1; rd_cmd = 1'b1;
    repeat (4) @(posedge clk);
    #1; wr_cmd = 1'b0; rd_cmd = 1'b0;
    repeat (10) @(posedge clk);
    #1; wr_cmd = 1'b1; mosi_data = 8'h0F;
    repeat (5) @(posedge clk);
    #1; wr_cmd = 1'b0;
    repeat (200) @(posedge clk);
    check_drained();

    // Reset mid-transfer, command kept high across reset release
    @(posedge clk); #1;
    mosi_data = 8'h6E; slave_word = 8'hE7; wr_cmd = 1'b1; rd_cmd = 1'b1;
    repeat (36) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("async_reset", i, 32'({cs_a[i], sck_a[i], mosi_a[i], md_a[i]}),
            32'({1'b1, cpol_of(i), 1'b0, 8'h00}));
    end
    repeat (3) @(negedge clk);
    #1; rst = 1'b0;
    lowseen = 0;
    repeat (150) begin
      @(negedge clk);
      if (cs_a != {NDUT{1'b1}}) lowseen++;
    end
    check("no_restart", 0, 32'(lowseen), 32'd0);
    #1; wr_cmd = 1'b0; rd_cmd = 1'b0;
    repeat (3) @(posedge clk);

    // A fresh rising edge after reset starts a transfer again
    run_vec({1'b1, 1'b1, 8'hC3, 8'h18, 8'hC3, 8'h18}, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
